ebpf_shift_unit: RTL and testbench
==================================

Name: ebpf_shift_unit

Overview:
- Pipelined, parametrised shift unit for the eBPF processing core.
- Executes LSH, RSH and ARSH in both ALU64 and ALU32 forms with eBPF shift-amount masking.
- Sits in the execute stage beside the other ALU units and carries a tag so results re-associate with the issuing instruction.
- Uses a valid/ready handshake with per-stage bubble collapsing, so backpressure from writeback never drops an operation.

Parameters:
- DATA_W, 64: datapath width; power of two, ≥ 64.
- STAGES, 2: register stages, 1..log2(DATA_W); equals latency.
- TAG_W, 5: width of the opaque tag (destination register index).

Ports:
- clk  in  1  core clock
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  operation offered
- in_ready  out  1  unit accepts when in_valid & in_ready at posedge clk
- in_op  in  2  00 LSH, 01 RSH, 10 ARSH, 11 reserved
- in_alu32  in  1  1 = ALU32 form
- in_a  in  DATA_W  value to shift
- in_b  in  DATA_W  shift amount (only low bits used)
- in_tag  in  TAG_W  passthrough tag
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts
- out_data  out  DATA_W  result
- out_tag  out  TAG_W  tag of the result
- out_err  out  1  reserved op flagged, qualified by out_valid

Behaviour:
- Reset (async, rst=1): every stage valid, out_valid, out_data, out_tag and out_err go to 0. All in-flight operations are discarded. in_ready is 1 from the first cycle after release.
- Shift amount:
  - ALU64: b[log2(DATA_W)-1:0]
  - ALU32: b[4:0]
  - Upper bits of in_b are ignored.
- Operand preparation, in front of stage 0 (combinational):
  - ALU32 LSH/RSH: a = zero-extended a[31:0].
  - ALU32 ARSH: a = sign-extended a[31:0].
- Datapath:
  - Right-shift barrel of log2(DATA_W) levels. Fill bit is a[MSB] for ARSH, else 0.
  - LSH is implemented by bit-reversing the operand before the barrel and reversing the result after it.
  - Level i is registered in stage floor(i*STAGES/log2(DATA_W)); the final stage register drives the outputs.
- Result finishing:
  - ALU32: out_data = zero-extended low 32 bits (eBPF semantics), for all three ops.
  - Reserved op: out_data = 0, out_err = 1, still accepted and retired in order.
- Handshake:
  - Stage k loads when ready_k = ~valid_k | ready_{k+1}; the last stage uses out_ready.
  - in_ready = ready_0. A combinational ready chain is permitted.
  - Latency is exactly STAGES cycles from acceptance to out_valid when out_ready stays 1.
  - Throughput is 1 op/cycle.
- Backpressure:
  - out_valid, out_data, out_tag and out_err hold stable while out_valid & ~out_ready.
  - Up to STAGES ops are buffered before in_ready drops.
  - Bubbles collapse: an empty stage accepts even while downstream stalls.
- Ordering: results retire strictly in acceptance order; no op is lost or duplicated.
- Simultaneous accept and drain on a full pipe: all stages advance in the same cycle and in_ready stays 1.
- Amount 0: out_data = prepared operand (ALU32 forms zero-extended).

Decomposition:
- Package ebpf_alu_pkg:
  - enum shift_op_t {SH_LSH, SH_RSH, SH_ARSH, SH_RSVD}
  - function bit_reverse(DATA_W)
  - constant SHAMT_W = $clog2(DATA_W)
  - function stage_of_level(i, STAGES, SHAMT_W)
- Sub-module ebpf_shift_stage: a register slice holding valid, data, remaining shift amount, fill, op, alu32 and tag, plus a parametrised range of barrel levels. The top module generates STAGES instances and the pre/post logic.

Test Plan:
- ARSH64: a=0x8000_0000_0000_0000, b=4 → out_data=0xF800_0000_0000_0000, exactly STAGES cycles after accept, tag echoed.
- ALU32:
  - ARSH32 a=0x0000_0000_8000_0000, b=4 → 0x0000_0000_F800_0000.
  - LSH32 a=0xFFFF_FFFF_FFFF_FFFF, b=4 → 0x0000_0000_FFFF_FFF0.
  - RSH32 a=0xFFFF_FFFF_0000_0010, b=36 (masked to 4) → 0x0000_0000_0000_0001.
- Masking and reserved op:
  - RSH64 a=0x10, b=0x41 → 0x8.
  - LSH64 b=0 → out_data=a.
  - op=11 → out_data=0, out_err=1.
- Backpressure: stream 8 ops with tags 0..7 and out_ready=0 for 5 cycles. in_ready drops after STAGES accepts, outputs hold stable, and after release tags 0..7 emerge in order with no gaps at full rate.
- Bubble collapse: accept op, idle 1 cycle, accept op, out_ready=0 → both held, in_ready=1 until STAGES ops are buffered.
- Reset mid-operation: assert rst asynchronously with 2 ops in flight → out_valid=0 immediately. After release, the first new op returns correct data and no stale result appears.

Source files
------------

// File: rtl/ebpf_alu_pkg.sv
// Shared types and helpers for the eBPF ALU execute units.
// Holds the shift opcode encoding, the barrel level-to-stage mapping and a width-generic bit reverse.
package ebpf_alu_pkg;

    typedef enum logic [1:0] {
        SH_LSH  = 2'b00,
        SH_RSH  = 2'b01,
        SH_ARSH = 2'b10,
        SH_RSVD = 2'b11
    } shift_op_t;

    localparam int DATA_W_DEFAULT = 64;
    localparam int SHAMT_W        = $clog2(DATA_W_DEFAULT);
    // Widest datapath the generic helpers below can handle.
    localparam int MAX_W          = 256;

    function automatic logic [MAX_W-1:0] bit_reverse(input logic [MAX_W-1:0] v, input int w);
        logic [MAX_W-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_W; i++) begin
            if (i < w) r[i] = v[w-1-i];
        end
        return r;
    endfunction

    function automatic int stage_of_level(input int i, input int stages, input int shamt_w);
        return (i * stages) / shamt_w;
    endfunction

endpackage

// File: rtl/ebpf_shift_stage.sv
// One register slice of the shift pipeline: applies its share of barrel levels, then registers.
// The last slice also finishes the result (LSH un-reverse, ALU32 truncation, reserved-op zeroing).
module ebpf_shift_stage
    import ebpf_alu_pkg::*;
#(
    parameter int DATA_W    = 64,
    parameter int TAG_W     = 5,
    parameter int STAGES    = 2,
    parameter int STAGE_IDX = 0,
    parameter bit LAST      = 1'b0,
    localparam int AMT_W    = $clog2(DATA_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              up_valid,
    input  logic [DATA_W-1:0] up_data,
    input  logic [AMT_W-1:0]  up_amt,
    input  logic              up_fill,
    input  shift_op_t         up_op,
    input  logic              up_alu32,
    input  logic [TAG_W-1:0]  up_tag,
    output logic              valid,
    output logic [DATA_W-1:0] data,
    output logic [AMT_W-1:0]  amt,
    output logic              fill,
    output shift_op_t         op,
    output logic              alu32,
    output logic [TAG_W-1:0]  tag,
    output logic              err
);

    localparam logic [DATA_W-1:0] ONES = '1;

    logic [DATA_W-1:0] shifted;
    logic [DATA_W-1:0] finished;

    always_comb begin
        shifted = up_data;
        for (int i = 0; i < AMT_W; i++) begin
            if (stage_of_level(i, STAGES, AMT_W) == STAGE_IDX && up_amt[i]) begin
                shifted = (shifted >> (1 << i)) | (up_fill ? ~(ONES >> (1 << i)) : '0);
            end
        end
        finished = shifted;
        if (LAST) begin
            if (up_op == SH_LSH) finished = DATA_W'(bit_reverse(MAX_W'(shifted), DATA_W));
            if (up_alu32) finished = {{(DATA_W-32){1'b0}}, finished[31:0]};
            if (up_op == SH_RSVD) finished = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) valid <= 1'b0;
        else if (load) valid <= up_valid;
    end

    // Only the output slice has its payload cleared on reset; inner payload is qualified by valid.
    if (LAST) begin : g_out_regs
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                data  <= '0;
                amt   <= '0;
                fill  <= 1'b0;
                op    <= SH_LSH;
                alu32 <= 1'b0;
                tag   <= '0;
                err   <= 1'b0;
            end else if (load && up_valid) begin
                data  <= finished;
                amt   <= up_amt;
                fill  <= up_fill;
                op    <= up_op;
                alu32 <= up_alu32;
                tag   <= up_tag;
                err   <= (up_op == SH_RSVD);
            end
        end
    end else begin : g_mid_regs
        always_ff @(posedge clk) begin
            if (load && up_valid) begin
                data  <= finished;
                amt   <= up_amt;
                fill  <= up_fill;
                op    <= up_op;
                alu32 <= up_alu32;
                tag   <= up_tag;
                err   <= (up_op == SH_RSVD);
            end
        end
    end

endmodule

// File: rtl/ebpf_shift_unit.sv
// Pipelined eBPF LSH/RSH/ARSH unit (ALU64 and ALU32) with tag passthrough and valid/ready flow.
// LSH reuses the right-shift barrel by reversing the operand on the way in and the result on the way out.
module ebpf_shift_unit
    import ebpf_alu_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int STAGES = 2,
    parameter int TAG_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_op,
    input  logic              in_alu32,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [TAG_W-1:0]  out_tag,
    output logic              out_err
);

    localparam int AMT_W = $clog2(DATA_W);

    shift_op_t         op_in;
    logic [DATA_W-1:0] prep;
    logic [DATA_W-1:0] barrel_in;
    logic [AMT_W-1:0]  amt_in;
    logic              fill_in;

    always_comb begin
        op_in = shift_op_t'(in_op);
        prep  = in_a;
        if (in_alu32) begin
            prep = (op_in == SH_ARSH) ? {{(DATA_W-32){in_a[31]}}, in_a[31:0]}
                                      : {{(DATA_W-32){1'b0}}, in_a[31:0]};
        end
        fill_in   = (op_in == SH_ARSH) && prep[DATA_W-1];
        barrel_in = (op_in == SH_LSH) ? DATA_W'(bit_reverse(MAX_W'(prep), DATA_W)) : prep;
        amt_in    = in_alu32 ? {{(AMT_W-5){1'b0}}, in_b[4:0]} : in_b[AMT_W-1:0];
    end

    // Index 0 is the prepared operand; index k+1 is the register output of stage k.
    logic [STAGES:0]   valid_a;
    logic [STAGES-1:0] load_v;
    logic [DATA_W-1:0] data_a  [STAGES+1];
    logic [AMT_W-1:0]  amt_a   [STAGES+1];
    logic              fill_a  [STAGES+1];
    shift_op_t         op_a    [STAGES+1];
    logic              alu32_a [STAGES+1];
    logic [TAG_W-1:0]  tag_a   [STAGES+1];
    logic              err_a   [STAGES+1];

    assign valid_a[0] = in_valid;
    assign data_a[0]  = barrel_in;
    assign amt_a[0]   = amt_in;
    assign fill_a[0]  = fill_in;
    assign op_a[0]    = op_in;
    assign alu32_a[0] = in_alu32;
    assign tag_a[0]   = in_tag;
    assign err_a[0]   = 1'b0;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        // A stage may load if some slot at or after it is empty or the consumer is taking data.
        assign load_v[k] = out_ready | ~(&valid_a[STAGES:k+1]);

        ebpf_shift_stage #(
            .DATA_W    (DATA_W),
            .TAG_W     (TAG_W),
            .STAGES    (STAGES),
            .STAGE_IDX (k),
            .LAST      (k == STAGES-1)
        ) u_stage (
            .clk      (clk),
            .rst      (rst),
            .load     (load_v[k]),
            .up_valid (valid_a[k]),
            .up_data  (data_a[k]),
            .up_amt   (amt_a[k]),
            .up_fill  (fill_a[k]),
            .up_op    (op_a[k]),
            .up_alu32 (alu32_a[k]),
            .up_tag   (tag_a[k]),
            .valid    (valid_a[k+1]),
            .data     (data_a[k+1]),
            .amt      (amt_a[k+1]),
            .fill     (fill_a[k+1]),
            .op       (op_a[k+1]),
            .alu32    (alu32_a[k+1]),
            .tag      (tag_a[k+1]),
            .err      (err_a[k+1])
        );
    end

    assign in_ready  = load_v[0];
    assign out_valid = valid_a[STAGES];
    assign out_data  = data_a[STAGES];
    assign out_tag   = tag_a[STAGES];
    assign out_err   = err_a[STAGES];

    // Shift-amount upper bits and the last slice's pass-through fields have no consumer.
    logic unused_bits;
    assign unused_bits = ^{in_b[DATA_W-1:AMT_W], amt_a[STAGES], fill_a[STAGES],
                           op_a[STAGES], alu32_a[STAGES]};

endmodule

// File: tb/tb_ebpf_shift_unit.sv
// Scoreboard bench for ebpf_shift_unit: a reference model predicts each accepted op,
// results are popped in order as the unit retires them.
module tb_ebpf_shift_unit;

    localparam int DATA_W = 64;
    localparam int STAGES = 2;
    localparam int TAG_W  = 5;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [1:0]        in_op = 2'b00;
    logic              in_alu32 = 1'b0;
    logic [DATA_W-1:0] in_a = '0;
    logic [DATA_W-1:0] in_b = '0;
    logic [TAG_W-1:0]  in_tag = '0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [DATA_W-1:0] out_data;
    logic [TAG_W-1:0]  out_tag;
    logic              out_err;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [TAG_W-1:0]  tag;
        logic              err;
    } exp_t;

    exp_t sbq[$];

    always #5 clk = ~clk;

    ebpf_shift_unit #(.DATA_W(DATA_W), .STAGES(STAGES), .TAG_W(TAG_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_alu32  (in_alu32),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag),
        .out_err   (out_err)
    );

    function automatic exp_t model(input logic [1:0] op, input logic alu32,
                                   input logic [63:0] a, input logic [63:0] b,
                                   input logic [TAG_W-1:0] tag);
        exp_t e;
        logic [31:0] x;
        logic [31:0] r32;
        logic [63:0] r64;
        int s;
        e.tag = tag;
        e.err = 1'b0;
        e.data = '0;
        r32 = '0;
        r64 = '0;
        if (op == 2'b11) begin
            e.err = 1'b1;
        end else if (alu32) begin
            x = a[31:0];
            s = int'(b[4:0]);
            case (op)
                2'b00:   r32 = x << s;
                2'b01:   r32 = x >> s;
                default: r32 = $signed(x) >>> s;
            endcase
            e.data = {32'd0, r32};
        end else begin
            s = int'(b[5:0]);
            case (op)
                2'b00:   r64 = a << s;
                2'b01:   r64 = a >> s;
                default: r64 = $signed(a) >>> s;
            endcase
            e.data = r64;
        end
        return e;
    endfunction

    // Mid-cycle: record accepts and retire outputs that will transfer at the next edge.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            sbq.delete();
        end else begin
            if (in_valid && in_ready) sbq.push_back(model(in_op, in_alu32, in_a, in_b, in_tag));
            if (out_valid && out_ready) begin
                checks++;
                if (sbq.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output got tag=%0d data=%h, required no output", out_tag, out_data);
                end else begin
                    e = sbq.pop_front();
                    if ({out_data, out_tag, out_err} !== {e.data, e.tag, e.err}) begin
                        errors++;
                        $display("FAIL result got data=%h tag=%0d err=%b, required data=%h tag=%0d err=%b",
                                 out_data, out_tag, out_err, e.data, e.tag, e.err);
                    end
                end
            end
        end
    end

    task automatic send(input logic [1:0] op, input logic alu32, input logic [63:0] a,
                        input logic [63:0] b, input logic [TAG_W-1:0] tag);
        bit accepted = 1'b0;
        in_op = op; in_alu32 = alu32; in_a = a; in_b = b; in_tag = tag;
        in_valid = 1'b1;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (in_ready) begin
                accepted = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        if (accepted) begin
            @(posedge clk); #1;
        end else begin
            checks++; errors++;
            $display("FAIL send_timeout tag=%0d got in_ready=0, required 1 within 50 cycles", tag);
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        bit done = 1'b0;
        for (int n = 0; n < 100; n++) begin
            @(posedge clk); #1;
            if (sbq.size() == 0 && !out_valid) begin
                done = 1'b1;
                break;
            end
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL drain_timeout got %0d pending, required 0", sbq.size());
        end
    endtask

    task automatic test_reset();
        #2 rst = 1'b1;
        #1;
        checks += 4;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b, required 0", out_valid); end
        if (out_data !== '0) begin errors++; $display("FAIL reset_out_data got %h, required 0", out_data); end
        if (out_tag !== '0) begin errors++; $display("FAIL reset_out_tag got %0d, required 0", out_tag); end
        if (out_err !== 1'b0) begin errors++; $display("FAIL reset_out_err got %b, required 0", out_err); end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b, required 1", in_ready); end
    endtask

    task automatic test_arsh64_latency();
        int cycles = 0;
        out_ready = 1'b1;
        in_op = 2'b10; in_alu32 = 1'b0; in_a = 64'h8000_0000_0000_0000; in_b = 64'd4; in_tag = 5'd9;
        in_valid = 1'b1;
        for (int n = 0; n < 20; n++) begin
            @(posedge clk); #1;
            in_valid = 1'b0;
            cycles++;
            if (out_valid) break;
        end
        checks += 4;
        if (cycles != STAGES) begin errors++; $display("FAIL arsh64_latency got %0d, required %0d", cycles, STAGES); end
        if (out_data !== 64'hF800_0000_0000_0000) begin errors++; $display("FAIL arsh64_data got %h, required f800000000000000", out_data); end
        if (out_tag !== 5'd9) begin errors++; $display("FAIL arsh64_tag got %0d, required 9", out_tag); end
        if (out_err !== 1'b0) begin errors++; $display("FAIL arsh64_err got %b, required 0", out_err); end
        wait_drain();
    endtask

    task automatic test_alu32();
        out_ready = 1'b1;
        send(2'b10, 1'b1, 64'h0000_0000_8000_0000, 64'd4,  5'd1);
        send(2'b00, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd4,  5'd2);
        send(2'b01, 1'b1, 64'hFFFF_FFFF_0000_0010, 64'd36, 5'd3);
        send(2'b00, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0,  5'd4);
        send(2'b10, 1'b1, 64'h1234_5678_FFFF_FFFE, 64'd63, 5'd5);
        wait_drain();
    endtask

    task automatic test_mask_rsvd();
        out_ready = 1'b1;
        send(2'b01, 1'b0, 64'h10, 64'h41, 5'd6);
        send(2'b00, 1'b0, 64'h0123_4567_89AB_CDEF, 64'd0, 5'd7);
        send(2'b11, 1'b0, 64'hDEAD_BEEF_DEAD_BEEF, 64'd3, 5'd8);
        send(2'b00, 1'b0, 64'h1, 64'hFFFF_FFFF_FFFF_FFFF, 5'd10);
        send(2'b10, 1'b0, 64'h8000_0000_0000_0001, 64'd63, 5'd11);
        wait_drain();
    endtask

    task automatic test_backpressure();
        int idx = 0;
        int emitted = 0;
        bit acc;
        bit ret;
        logic [DATA_W-1:0] snap_data = '0;
        logic [TAG_W-1:0]  snap_tag = '0;
        for (int cyc = 0; cyc < 60 && emitted < 8; cyc++) begin
            out_ready = (cyc >= 5);
            in_valid  = (idx < 8);
            in_op     = 2'(idx % 3);
            in_alu32  = idx[0];
            in_a      = 64'hF0F0_1234_5678_9ABC ^ 64'(idx);
            in_b      = 64'(idx + 1);
            in_tag    = TAG_W'(idx);
            @(negedge clk);
            if (cyc < STAGES) begin
                checks++;
                if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_fill_ready cyc=%0d got %b, required 1", cyc, in_ready); end
            end
            if (cyc == STAGES) begin
                checks += 2;
                if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_full_ready got %b, required 0", in_ready); end
                if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid got %b, required 1", out_valid); end
                snap_data = out_data;
                snap_tag  = out_tag;
            end
            if (cyc > STAGES && cyc < 5) begin
                checks++;
                if (!(out_valid === 1'b1 && out_data === snap_data && out_tag === snap_tag)) begin
                    errors++;
                    $display("FAIL bp_hold cyc=%0d got valid=%b data=%h tag=%0d, required 1 %h %0d",
                             cyc, out_valid, out_data, out_tag, snap_data, snap_tag);
                end
            end
            if (cyc >= 5) begin
                checks++;
                if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_gap cyc=%0d got out_valid=%b, required 1", cyc, out_valid); end
            end
            acc = in_valid && in_ready;
            ret = out_valid && out_ready;
            @(posedge clk); #1;
            if (acc) idx++;
            if (ret) emitted++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        checks++;
        if (emitted != 8) begin errors++; $display("FAIL bp_count got %0d, required 8", emitted); end
        wait_drain();
    endtask

    task automatic test_bubble();
        out_ready = 1'b0;
        send(2'b01, 1'b0, 64'hFF00, 64'd8, 5'd20);
        @(negedge clk);
        checks += 2;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL bubble_idle_ready got %b, required 1", in_ready); end
        if (out_valid !== 1'b0) begin errors++; $display("FAIL bubble_idle_valid got %b, required 0", out_valid); end
        @(posedge clk); #1;
        checks += 3;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL bubble_collapse_ready got %b, required 1", in_ready); end
        if (out_valid !== 1'b1) begin errors++; $display("FAIL bubble_head_valid got %b, required 1", out_valid); end
        if (out_tag !== 5'd20) begin errors++; $display("FAIL bubble_head_tag got %0d, required 20", out_tag); end
        send(2'b00, 1'b0, 64'h3, 64'd2, 5'd21);
        @(negedge clk);
        checks += 2;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL bubble_full_ready got %b, required 0", in_ready); end
        if (out_tag !== 5'd20) begin errors++; $display("FAIL bubble_hold_tag got %0d, required 20", out_tag); end
        @(posedge clk); #1;
        out_ready = 1'b1;
        wait_drain();
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b1;
        send(2'b01, 1'b0, 64'hAAAA_0000, 64'd4, 5'd12);
        send(2'b00, 1'b0, 64'h5555, 64'd4, 5'd13);
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL midreset_inflight got %b, required 1", out_valid); end
        #2 rst = 1'b1;
        #1;
        checks += 3;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL midreset_valid got %b, required 0", out_valid); end
        if (out_data !== '0) begin errors++; $display("FAIL midreset_data got %h, required 0", out_data); end
        if (out_tag !== '0) begin errors++; $display("FAIL midreset_tag got %0d, required 0", out_tag); end
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL midreset_ready got %b, required 1", in_ready); end
        send(2'b10, 1'b1, 64'h0000_0000_C000_0000, 64'd2, 5'd14);
        wait_drain();
    endtask

    task automatic test_back_to_back();
        int sent = 0;
        bit acc;
        for (int cyc = 0; cyc < 400 && (sent < 40 || in_valid); cyc++) begin
            if (!in_valid && sent < 40 && $urandom_range(0, 3) != 0) begin
                in_op    = 2'($urandom_range(0, 3));
                in_alu32 = 1'($urandom_range(0, 1));
                in_a     = {$urandom, $urandom};
                in_b     = {$urandom, $urandom};
                in_tag   = TAG_W'($urandom);
                in_valid = 1'b1;
                sent++;
            end
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            if (acc) in_valid = 1'b0;
        end
        checks++;
        if (in_valid) begin errors++; $display("FAIL b2b_timeout got in_valid stuck, required all accepted"); end
        in_valid = 1'b0;
        out_ready = 1'b1;
        wait_drain();
    endtask

    initial begin
        test_reset();
        test_arsh64_latency();
        test_alu32();
        test_mask_rsvd();
        test_backpressure();
        test_bubble();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got no completion, required finish within 500000 time units");
        $fatal(1, "watchdog expired");
    end

endmodule
